// File: rtl/multiplicador_sequencial.sv
// Shift-and-add multiplier, one multiplier bit per cycle; `MULTIPLICADOR_SIGNED_EN selects two's complement.
// Latency: done pulses WIDTH cycles after start is accepted; P holds until the next done.
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.
module multiplicador_sequencial #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     pp, hi, sum;
  logic               accept, last_step;

  // Partial product enters a WIDTH+1 adder against the upper half of acc.
  always_comb begin
`ifdef MULTIPLICADOR_SIGNED_EN
    pp  = b_reg[0] ? {a_reg[WIDTH-1], a_reg} : '0;
    hi  = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
    sum = last_step ? (hi - pp) : (hi + pp);
`else
    pp  = b_reg[0] ? {1'b0, a_reg} : '0;
    hi  = {1'b0, acc[2*WIDTH-1:WIDTH]};
    sum = hi + pp;
`endif
    // The carry/sign bit lands in the MSB, so this one concat is the right shift.
    acc_step = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_step;
      if (accept) begin
        a_reg <= A;
        b_reg <= B;
        acc   <= '0;
        cnt   <= '0;
      end else if (busy) begin
        acc   <= acc_step;
        b_reg <= b_reg >> 1;
        cnt   <= cnt + 1'b1;
        if (last_step) P <= acc_step;
      end
    end
  end

endmodule
